// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC, issues one instruction-memory request at a time over a
// valid/ready port, and drives the IF/ID register read by decode and the
// hazard unit. A one-entry skid buffer holds a response that arrives while
// the hazard unit is freezing IF/ID. EX redirects discard anything in flight.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   stall_hold               1 = hold PC and IF/ID (hazard unit freeze)
//   redirect_valid/_pc       taken branch/jump resolved in EX, and its target
//   imem_req_valid/_ready    fetch request handshake
//   imem_req_addr            fetch address (the PC register)
//   imem_rsp_valid/_data     returned instruction word
//   ifid_valid/_pc/_instr    IF/ID pipeline register
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_hold,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]      state_p0;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] inflight_pc_p0;

  logic            skid_vld_p1;
  logic [XLEN-1:0] skid_pc_p1;
  logic [31:0]     skid_instr_p1;

  logic            ifid_vld_p2;
  logic [XLEN-1:0] ifid_pc_p2;
  logic [31:0]     ifid_instr_p2;

  logic req_fire;
  logic rsp_deliver;

  // Sequential fetch address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  // ---- p0: request issue / PC ----
  // A request is withheld while a redirect is changing the PC and while the
  // skid buffer is occupied, so a skid entry can never meet a new delivery.
  assign imem_req_valid = !rst && (state_p0 == ST_REQ) && !redirect_valid && !skid_vld_p1;
  assign imem_req_addr  = pc_p0;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response only counts in WAIT and only if no redirect kills it.
  assign rsp_deliver    = (state_p0 == ST_WAIT) && imem_rsp_valid && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_REQ;
      pc_p0    <= RESET_PC;
    end else begin
      case (state_p0)
        ST_REQ: begin
          if (req_fire) state_p0 <= ST_WAIT;
        end
        ST_WAIT: begin
          // Redirect without a response leaves one stale response to absorb.
          if (imem_rsp_valid)      state_p0 <= ST_REQ;
          else if (redirect_valid) state_p0 <= ST_DROP;
        end
        ST_DROP: begin
          if (imem_rsp_valid) state_p0 <= ST_REQ;
        end
        default: state_p0 <= ST_REQ;
      endcase

      if (redirect_valid)  pc_p0 <= redirect_pc;
      else if (req_fire)   pc_p0 <= pc_plus4(pc_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) inflight_pc_p0 <= pc_p0;
  end

  // ---- p1: skid buffer ----
  always_ff @(posedge clk) begin
    if (!redirect_valid && stall_hold && rsp_deliver) begin
      skid_pc_p1    <= inflight_pc_p0;
      skid_instr_p1 <= imem_rsp_data;
    end
  end

  // ---- p2: IF/ID register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_p1   <= 1'b0;
      ifid_vld_p2   <= 1'b0;
      ifid_pc_p2    <= '0;
      ifid_instr_p2 <= NOP_INSTR;
    end else if (redirect_valid) begin
      skid_vld_p1 <= 1'b0;
      ifid_vld_p2 <= 1'b0;
    end else if (stall_hold) begin
      if (rsp_deliver) skid_vld_p1 <= 1'b1;
    end else if (skid_vld_p1) begin
      ifid_vld_p2   <= 1'b1;
      ifid_pc_p2    <= skid_pc_p1;
      ifid_instr_p2 <= skid_instr_p1;
      skid_vld_p1   <= 1'b0;
    end else if (rsp_deliver) begin
      ifid_vld_p2   <= 1'b1;
      ifid_pc_p2    <= inflight_pc_p0;
      ifid_instr_p2 <= imem_rsp_data;
    end else begin
      // Bubble: PC and instruction are left as they were.
      ifid_vld_p2 <= 1'b0;
    end
  end

  assign ifid_valid = ifid_vld_p2;
  assign ifid_pc    = ifid_pc_p2;
  assign ifid_instr = ifid_instr_p2;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: testbench for fetch_stage.
//
// Directed table of fetch/stall cycles, hand-written redirect, wrap and
// asynchronous-reset sequences, then a randomized run compared against a
// transaction-level model (outstanding-request record, skid slot, IF/ID).
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_hold;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  int errors;
  int checks;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_hold     (stall_hold),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_qv;
  logic        m_qdisc;
  logic [31:0] m_qaddr;
  logic        m_bufv;
  logic [31:0] m_bufpc;
  logic [31:0] m_bufinstr;
  logic        m_ifv;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifinstr;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        rsp;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_ifv;
    logic [31:0] exp_ifpc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl [13];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic rv, input logic [31:0] d);
    stall_hold     = s;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_qv = 1'b0; m_qdisc = 1'b0; m_qaddr = 32'h0;
    m_bufv = 1'b0; m_bufpc = 32'h0; m_bufinstr = 32'h0;
    m_ifv = 1'b0; m_ifpc = 32'h0; m_ifinstr = NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk1 ("rst_req_valid", imem_req_valid, 1'b0);
    chk1 ("rst_ifid_valid", ifid_valid, 1'b0);
    chk32("rst_ifid_pc", ifid_pc, 32'h0);
    chk32("rst_ifid_instr", ifid_instr, NOP);
    chk32("rst_pc", imem_req_addr, 32'h0);
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle of the fetch stage at transaction level: an outstanding fetch
  // is either delivered, killed by a redirect, or marked to be thrown away;
  // delivered words go to IF/ID or, under a freeze, to the single skid slot.
  task automatic model_step(input logic s, input logic rd, input logic [31:0] rpc,
                            input logic rdy, input logic rv, input logic [31:0] d,
                            output logic fire);
    logic        got;
    logic [31:0] w_pc;
    fire = !m_qv && !rd && !m_bufv && rdy;
    got  = 1'b0;
    w_pc = m_qaddr;
    if (m_qv && rv) begin
      m_qv = 1'b0;
      got  = !m_qdisc && !rd;
    end else if (m_qv && rd) begin
      m_qdisc = 1'b1;
    end
    if (fire) begin
      m_qv = 1'b1; m_qaddr = m_pc; m_qdisc = 1'b0; m_pc = m_pc + 32'd4;
    end
    if (rd) begin
      m_pc = rpc; m_ifv = 1'b0; m_bufv = 1'b0;
    end else if (s) begin
      if (got) begin m_bufv = 1'b1; m_bufpc = w_pc; m_bufinstr = d; end
    end else if (m_bufv) begin
      m_ifv = 1'b1; m_ifpc = m_bufpc; m_ifinstr = m_bufinstr; m_bufv = 1'b0;
    end else if (got) begin
      m_ifv = 1'b1; m_ifpc = w_pc; m_ifinstr = d;
    end else begin
      m_ifv = 1'b0;
    end
  endtask

  initial begin
    logic        r_stall, r_redir, r_ready, r_rsp, fire, pend;
    logic [31:0] r_rpc, r_data;
    int          cnt;

    errors = 0;
    checks = 0;

    // stall, ready, rsp, data | req, addr, ifv, ifpc, instr
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h00, 1'b0, 32'h0, NOP};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'hC0DE_0000, 1'b0, 32'h04, 1'b0, 32'h0, NOP};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h04, 1'b1, 32'h0, 32'hC0DE_0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'hC0DE_0001, 1'b0, 32'h08, 1'b0, 32'h0, 32'hC0DE_0000};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h08, 1'b1, 32'h4, 32'hC0DE_0001};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'hC0DE_0002, 1'b0, 32'h0C, 1'b0, 32'h4, 32'hC0DE_0001};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0C, 1'b1, 32'h8, 32'hC0DE_0002};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'hC0DE_0003, 1'b0, 32'h10, 1'b1, 32'h8, 32'hC0DE_0002};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h10, 1'b1, 32'h8, 32'hC0DE_0002};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h10, 1'b1, 32'h8, 32'hC0DE_0002};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h10, 1'b1, 32'h8, 32'hC0DE_0002};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h10, 1'b1, 32'hC, 32'hC0DE_0003};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'hC0DE_0004, 1'b0, 32'h14, 1'b0, 32'hC, 32'hC0DE_0003};

    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].stall, 1'b0, 32'h0, tbl[i].ready, tbl[i].rsp, tbl[i].data);
      @(negedge clk);
      chk1 ($sformatf("tbl%0d_req", i), imem_req_valid, tbl[i].exp_req);
      chk32($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].exp_addr);
      chk1 ($sformatf("tbl%0d_ifv", i), ifid_valid, tbl[i].exp_ifv);
      chk32($sformatf("tbl%0d_ifpc", i), ifid_pc, tbl[i].exp_ifpc);
      chk32($sformatf("tbl%0d_instr", i), ifid_instr, tbl[i].exp_instr);
      tick();
    end

    // Redirect while waiting; late response must be dropped.
    do_reset();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("a_req0", imem_req_valid, 1'b1); tick();
    drive(0, 1, 32'h100, 1, 0, 32'h0);
    @(negedge clk); chk1("a_redir_noreq", imem_req_valid, 1'b0); tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("a_drop_noreq", imem_req_valid, 1'b0);
    chk32("a_drop_pc", imem_req_addr, 32'h100); tick();
    drive(0, 0, 32'h0, 1, 1, 32'hDEAD_DEAD);
    @(negedge clk); chk1("a_drop_noreq2", imem_req_valid, 1'b0); tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("a_req_after", imem_req_valid, 1'b1);
    chk32("a_addr_after", imem_req_addr, 32'h100);
    chk1("a_ifv_dropped", ifid_valid, 1'b0); tick();

    // Redirect and response in the same WAIT cycle.
    drive(0, 1, 32'h200, 1, 1, 32'hBEEF_BEEF);
    @(negedge clk); chk1("b_noreq", imem_req_valid, 1'b0); tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("b_req", imem_req_valid, 1'b1);
    chk32("b_addr", imem_req_addr, 32'h200);
    chk1("b_ifv", ifid_valid, 1'b0); tick();

    // Redirect while frozen with a word in the skid buffer.
    drive(0, 0, 32'h0, 1, 1, 32'hC1C1_C1C1);
    @(negedge clk); tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("c_ifv_deliv", ifid_valid, 1'b1);
    chk32("c_ifpc_deliv", ifid_pc, 32'h200);
    chk32("c_instr_deliv", ifid_instr, 32'hC1C1_C1C1); tick();
    drive(1, 0, 32'h0, 1, 1, 32'hC2C2_C2C2);
    @(negedge clk); tick();
    drive(1, 1, 32'h300, 1, 0, 32'h0);
    @(negedge clk); chk1("c_skid_noreq", imem_req_valid, 1'b0);
    chk1("c_held_ifv", ifid_valid, 1'b1);
    chk32("c_held_ifpc", ifid_pc, 32'h200); tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("c_ifv_killed", ifid_valid, 1'b0);
    chk1("c_req", imem_req_valid, 1'b1);
    chk32("c_addr", imem_req_addr, 32'h300); tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("c_skid_cleared", ifid_valid, 1'b0); tick();

    // PC wrap and asynchronous reset in WAIT.
    drive(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0);
    @(negedge clk); tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("d_req_top", imem_req_valid, 1'b1);
    chk32("d_addr_top", imem_req_addr, 32'hFFFF_FFFC); tick();
    drive(0, 0, 32'h0, 1, 1, 32'hC3C3_C3C3);
    @(negedge clk); chk32("d_wrap", imem_req_addr, 32'h0); tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("d_ifv", ifid_valid, 1'b1);
    chk32("d_ifpc", ifid_pc, 32'hFFFF_FFFC);
    chk32("d_instr", ifid_instr, 32'hC3C3_C3C3); tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk); chk1("d_pre_ifv", ifid_valid, 1'b1);
    chk32("d_pre_addr", imem_req_addr, 32'h4);
    #1 rst = 1'b1;
    #1;
    chk1 ("d_arst_req", imem_req_valid, 1'b0);
    chk1 ("d_arst_ifv", ifid_valid, 1'b0);
    chk32("d_arst_pc", imem_req_addr, 32'h0);
    chk32("d_arst_ifpc", ifid_pc, 32'h0);
    chk32("d_arst_instr", ifid_instr, NOP);
    tick();
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk); chk1("d_post_req", imem_req_valid, 1'b1);
    chk32("d_post_addr", imem_req_addr, 32'h0); tick();

    // Randomized run against the model.
    do_reset();
    pend = 1'b0;
    cnt  = 0;
    for (int n = 0; n < 3000; n++) begin
      r_stall = ($urandom % 4) == 0;
      r_redir = ($urandom % 12) == 0;
      r_rpc   = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
      r_ready = ($urandom % 3) != 0;
      if (pend) r_rsp = (cnt == 0);
      else      r_rsp = ($urandom % 8) == 0;
      r_data  = $urandom;
      drive(r_stall, r_redir, r_rpc, r_ready, r_rsp, r_data);
      @(negedge clk);
      chk1 ("rnd_req", imem_req_valid, !m_qv && !r_redir && !m_bufv);
      chk32("rnd_addr", imem_req_addr, m_pc);
      chk1 ("rnd_ifv", ifid_valid, m_ifv);
      chk32("rnd_ifpc", ifid_pc, m_ifpc);
      chk32("rnd_instr", ifid_instr, m_ifinstr);
      model_step(r_stall, r_redir, r_rpc, r_ready, r_rsp, r_data, fire);
      if (pend && r_rsp)      pend = 1'b0;
      else if (pend && cnt > 0) cnt--;
      if (fire) begin
        pend = 1'b1;
        cnt  = $urandom_range(0, 2);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
